byte_unstrip: RTL and testbench

BYTE_UNSTRIP -- requirements
Module: byte_unstrip

---
 rtl/byte_unstrip_pkg.sv | 40 ++++
 rtl/byte_unstrip_if.sv | 26 ++
 rtl/lane_word_fifo.sv | 45 ++++
 rtl/byte_unstrip.sv | 117 +++++++++++
 tb/tb_byte_unstrip.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/byte_unstrip_pkg.sv
// Shared framing symbols, error encodings and word types for the byte strip/unstrip pair.
package byte_unstrip_pkg;

  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_IDL = 8'h7C;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'b00,
    ERR_MISPLACED    = 2'b01,
    ERR_START_IN_PKT = 2'b10,
    ERR_END_OUT_PKT  = 2'b11
  } err_code_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } frame_state_t;

  // Each lane carries its own copy of the word's DK flag, giving a 36-bit FIFO entry.
  typedef struct packed {
    logic       dk;
    logic [7:0] data;
  } lane_byte_t;

  typedef lane_byte_t [3:0] lane_word_t;

  function automatic logic is_start(input logic [7:0] b);
    return (b == SYM_STP) || (b == SYM_SDP);
  endfunction

  function automatic logic is_end(input logic [7:0] b);
    return (b == SYM_END) || (b == SYM_EDB);
  endfunction

endpackage

// File: rtl/byte_unstrip_if.sv
// Striped-word input handshake plus serialized byte output of byte_unstrip.
interface byte_unstrip_if;
  logic [7:0] LANE0;
  logic [7:0] LANE1;
  logic [7:0] LANE2;
  logic [7:0] LANE3;
  logic       i_DK;
  logic       LANES_VALID;
  logic       LANES_READY;
  logic [7:0] D;
  logic       o_DK;
  logic       VALID;
  logic       PKT_ACTIVE;
  logic       ERR;
  logic [1:0] ERR_CODE;

  modport slave (
    input  LANE0, LANE1, LANE2, LANE3, i_DK, LANES_VALID,
    output LANES_READY, D, o_DK, VALID, PKT_ACTIVE, ERR, ERR_CODE
  );

  modport master (
    output LANE0, LANE1, LANE2, LANE3, i_DK, LANES_VALID,
    input  LANES_READY, D, o_DK, VALID, PKT_ACTIVE, ERR, ERR_CODE
  );
endinterface

// File: rtl/lane_word_fifo.sv
// Two-entry word FIFO with a registered not-full ready flag.
module lane_word_fifo #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         not_empty,
  output logic         ready
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [1:0]   count_next;

  // A pop and push in the same cycle leave the occupancy unchanged.
  always_comb count_next = count + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      ready  <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count_next;
      ready <= (count_next != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata     = mem[rd_ptr];
  assign not_empty = (count != 2'd0);

endmodule

// File: rtl/byte_unstrip.sv
// Serializes 4-lane striped words into a byte stream and checks packet framing.
//   state     | meaning
//   ST_IDLE   | outside a packet, waiting for STP/SDP on lane0
//   ST_IN_PKT | between an accepted start symbol and END/EDB on lane3
module byte_unstrip
  import byte_unstrip_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int LANES = 4
) (
  input logic           CLK,
  input logic           RESET_L,
  byte_unstrip_if.slave bus
);

  localparam int WORD_W = LANES * (BITS + 1);

  lane_word_t   in_word;
  lane_word_t   head;
  lane_word_t   cur;
  lane_byte_t   cur_byte;
  logic         push;
  logic         pop;
  logic         fifo_ne;
  logic         busy;
  logic [1:0]   cnt;
  logic         sym_start;
  logic         sym_end;
  logic         misplaced;
  frame_state_t state;
  frame_state_t state_next;
  logic [7:0]   d_out;
  logic         dk_out;
  logic         valid_out;
  err_code_t    err_out;

  assign in_word = {{bus.i_DK, bus.LANE3}, {bus.i_DK, bus.LANE2},
                    {bus.i_DK, bus.LANE1}, {bus.i_DK, bus.LANE0}};
  assign push    = bus.LANES_VALID & bus.LANES_READY;
  assign pop     = fifo_ne & (~busy | (cnt == 2'd3));

  lane_word_fifo #(.W(WORD_W)) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET_L),
    .push      (push),
    .wdata     (in_word),
    .pop       (pop),
    .rdata     (head),
    .not_empty (fifo_ne),
    .ready     (bus.LANES_READY)
  );

  // Reloading on the lane3 cycle keeps the byte stream gapless.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      cur  <= '0;
      busy <= 1'b0;
      cnt  <= 2'd0;
    end else if (pop) begin
      cur  <= head;
      busy <= 1'b1;
      cnt  <= 2'd0;
    end else if (busy && cnt == 2'd3) begin
      busy <= 1'b0;
      cnt  <= 2'd0;
    end else if (busy) begin
      cnt  <= cnt + 2'd1;
    end
  end

  assign cur_byte  = cur[cnt];
  assign sym_start = busy & is_start(cur_byte.data);
  assign sym_end   = busy & is_end(cur_byte.data);
  assign misplaced = (sym_start && cnt != 2'd0) || (sym_end && cnt != 2'd3);

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!misplaced) begin
      if (sym_start)    state_next = ST_IN_PKT;
      else if (sym_end) state_next = ST_IDLE;
    end
  end

  // Misplaced symbols are scrubbed to IDL and win over the context errors.
  always_comb begin
    d_out     = SYM_IDL;
    dk_out    = 1'b1;
    valid_out = 1'b0;
    err_out   = ERR_NONE;
    if (busy) begin
      valid_out = 1'b1;
      dk_out    = cur_byte.dk;
      d_out     = cur_byte.data;
      if (misplaced) begin
        d_out   = SYM_IDL;
        err_out = ERR_MISPLACED;
      end else if (sym_start && state == ST_IN_PKT) begin
        err_out = ERR_START_IN_PKT;
      end else if (sym_end && state == ST_IDLE) begin
        err_out = ERR_END_OUT_PKT;
      end
    end
  end

  assign bus.D          = d_out;
  assign bus.o_DK       = dk_out;
  assign bus.VALID      = valid_out;
  assign bus.ERR        = (err_out != ERR_NONE);
  assign bus.ERR_CODE   = err_out;
  assign bus.PKT_ACTIVE = (state == ST_IN_PKT);

endmodule

// File: tb/tb_byte_unstrip.sv
// Directed bench for byte_unstrip: framing model feeds a byte scoreboard checked on every VALID cycle.
module tb_byte_unstrip;

  typedef struct {
    logic [7:0] d;
    logic       dk;
    logic [1:0] code;
  } exp_t;

  logic CLK;
  logic RESET_L;
  byte_unstrip_if bus();

  byte_unstrip #(.BITS(8), .LANES(4)) dut (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .bus     (bus)
  );

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  bit   model_in_pkt = 0;
  int   run_len = 0;
  int   max_run = 0;
  bit   ready_low_seen = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_word(input logic [7:0] b0, b1, b2, b3, input logic dk);
    logic [7:0] bytes [4];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      bit st, en;
      st = (bytes[i] == 8'hFB) || (bytes[i] == 8'h5C);
      en = (bytes[i] == 8'hFD) || (bytes[i] == 8'hFE);
      e.d = bytes[i];
      e.dk = dk;
      e.code = 2'b00;
      if ((st && i != 0) || (en && i != 3)) begin
        e.d = 8'h7C;
        e.code = 2'b01;
      end else if (st) begin
        if (model_in_pkt) e.code = 2'b10;
        model_in_pkt = 1;
      end else if (en) begin
        if (!model_in_pkt) e.code = 2'b11;
        model_in_pkt = 0;
      end
      sb.push_back(e);
    end
  endtask

  // Leaves LANES_VALID high on return so consecutive calls are back-to-back.
  task automatic send_word(input logic [7:0] b0, b1, b2, b3, input logic dk);
    int guard = 0;
    @(negedge CLK);
    bus.LANE0 = b0; bus.LANE1 = b1; bus.LANE2 = b2; bus.LANE3 = b3;
    bus.i_DK = dk;
    bus.LANES_VALID = 1'b1;
    while (!bus.LANES_READY && guard < 40) begin
      @(negedge CLK);
      guard++;
    end
    check("ready_wait_bounded", 32'(guard < 40), 32'd1);
    @(posedge CLK);
    model_word(b0, b1, b2, b3, dk);
  endtask

  task automatic stop_valid();
    @(negedge CLK);
    bus.LANES_VALID = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    check("drain_bounded", 32'(guard < 100), 32'd1);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RESET_L === 1'b1) begin
      if (bus.VALID) begin
        if (sb.size() == 0) begin
          check("stale_or_extra_byte", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("d", bus.D, e.d);
          check("o_dk", bus.o_DK, e.dk);
          check("err_code", bus.ERR_CODE, e.code);
          check("err", bus.ERR, 32'(e.code != 2'b00));
        end
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
        check("idle_d", bus.D, 8'h7C);
        check("idle_dk", bus.o_DK, 1'b1);
        check("idle_err", {bus.ERR, bus.ERR_CODE}, 3'b000);
      end
      if (!bus.LANES_READY) ready_low_seen = 1;
    end
  end

  initial begin
    bus.LANE0 = 8'h00; bus.LANE1 = 8'h00; bus.LANE2 = 8'h00; bus.LANE3 = 8'h00;
    bus.i_DK = 1'b0;
    bus.LANES_VALID = 1'b0;
    RESET_L = 1'b1;
    #3 RESET_L = 1'b0;
    #1;
    check("rst_ready", bus.LANES_READY, 1'b0);
    check("rst_valid", bus.VALID, 1'b0);
    check("rst_d", bus.D, 8'h7C);
    check("rst_dk", bus.o_DK, 1'b1);
    check("rst_pkt", bus.PKT_ACTIVE, 1'b0);
    check("rst_err", {bus.ERR, bus.ERR_CODE}, 3'b000);
    @(negedge CLK);
    @(negedge CLK);
    RESET_L = 1'b1;
    @(posedge CLK);
    #1 check("ready_after_release", bus.LANES_READY, 1'b1);

    // Single start word: latency and PKT_ACTIVE timing.
    send_word(8'hFB, 8'h11, 8'h22, 8'h33, 1'b0);
    stop_valid();
    check("t1_not_yet_valid", bus.VALID, 1'b0);
    @(negedge CLK);
    check("t1_lane0_valid", bus.VALID, 1'b1);
    check("t1_lane0_d", bus.D, 8'hFB);
    check("t1_pkt_before", bus.PKT_ACTIVE, 1'b0);
    @(negedge CLK);
    check("t1_pkt_after", bus.PKT_ACTIVE, 1'b1);
    check("t1_lane1_d", bus.D, 8'h11);
    drain();
    send_word(8'hBC, 8'h1C, 8'h44, 8'hFD, 1'b1);
    stop_valid();
    drain();
    @(negedge CLK);
    check("t1_closed", bus.PKT_ACTIVE, 1'b0);

    // Three back-to-back words: gapless stream and ready backpressure.
    max_run = 0;
    ready_low_seen = 0;
    send_word(8'hFB, 8'h01, 8'h02, 8'h03, 1'b0);
    send_word(8'h04, 8'h05, 8'h06, 8'h07, 1'b1);
    send_word(8'h08, 8'h09, 8'h0A, 8'hFD, 1'b0);
    stop_valid();
    drain();
    @(negedge CLK);
    check("t2_contiguous", 32'(max_run), 32'd12);
    check("t2_ready_dropped", 32'(ready_low_seen), 32'd1);
    check("t2_ready_recovered", bus.LANES_READY, 1'b1);
    check("t2_pkt_closed", bus.PKT_ACTIVE, 1'b0);

    // Misplaced symbols and end outside packet.
    send_word(8'h10, 8'hFB, 8'h20, 8'hFD, 1'b1);
    send_word(8'hFD, 8'hBC, 8'h1C, 8'h7C, 1'b1);
    send_word(8'h5C, 8'hFE, 8'hA5, 8'hFE, 1'b0);
    stop_valid();
    drain();
    @(negedge CLK);
    check("t3_pkt_idle", bus.PKT_ACTIVE, 1'b0);

    // Start inside packet.
    send_word(8'h5C, 8'hA1, 8'hA2, 8'hA3, 1'b0);
    send_word(8'h5C, 8'hB1, 8'hB2, 8'hB3, 1'b0);
    stop_valid();
    drain();
    @(negedge CLK);
    check("t4_pkt_stays", bus.PKT_ACTIVE, 1'b1);
    send_word(8'hC1, 8'hC2, 8'hC3, 8'hFE, 1'b0);
    stop_valid();
    drain();
    @(negedge CLK);
    check("t4_pkt_closed", bus.PKT_ACTIVE, 1'b0);

    // Reset after the second byte of a word with another word queued.
    send_word(8'hC1, 8'hC2, 8'hC3, 8'hC4, 1'b1);
    send_word(8'hD1, 8'hD2, 8'hD3, 8'hD4, 1'b1);
    stop_valid();
    check("t5_byte1", bus.D, 8'hC1);
    @(negedge CLK);
    check("t5_byte2", bus.D, 8'hC2);
    #1 RESET_L = 1'b0;
    sb.delete();
    model_in_pkt = 0;
    #1;
    check("t5_rst_valid", bus.VALID, 1'b0);
    check("t5_rst_d", bus.D, 8'h7C);
    check("t5_rst_dk", bus.o_DK, 1'b1);
    check("t5_rst_ready", bus.LANES_READY, 1'b0);
    check("t5_rst_pkt", bus.PKT_ACTIVE, 1'b0);
    check("t5_rst_err", {bus.ERR, bus.ERR_CODE}, 3'b000);
    @(negedge CLK);
    @(negedge CLK);
    RESET_L = 1'b1;
    @(posedge CLK);
    #1 check("t5_ready_release", bus.LANES_READY, 1'b1);
    repeat (12) @(negedge CLK);
    send_word(8'hFB, 8'hBC, 8'h1C, 8'hFD, 1'b0);
    stop_valid();
    drain();
    @(negedge CLK);
    check("t5_pkt_final", bus.PKT_ACTIVE, 1'b0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
